// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit start validation, centre sampling.
// Emits a one-clock DV strobe per good byte and a one-clock ERR strobe on a low stop bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_CLK,
  input  logic       i_RST_N,
  input  logic       i_RX_SERIAL,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_BYTE,
  output logic       o_RX_ACTIVE,
  output logic       o_RX_ERR
);

  localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);
  localparam logic [7:0] FULL = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift;
  logic       rx_m;
  logic       rx_s;
  logic       break_wait;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_RX_SERIAL;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      idx         <= 3'd0;
      shift       <= 8'h00;
      break_wait  <= 1'b0;
      o_RX_DV     <= 1'b0;
      o_RX_BYTE   <= 8'h00;
      o_RX_ACTIVE <= 1'b0;
      o_RX_ERR    <= 1'b0;
    end else begin
      // Strobes default low so each is exactly one cycle wide.
      o_RX_DV  <= 1'b0;
      o_RX_ERR <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 8'd0;
          idx <= 3'd0;
          if (rx_s) break_wait <= 1'b0;
          if (!rx_s && !break_wait) begin
            state       <= START;
            o_RX_ACTIVE <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= 8'd0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state       <= IDLE;
              o_RX_ACTIVE <= 1'b0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DATA: begin
          if (cnt == FULL) begin
            cnt        <= 8'd0;
            shift[idx] <= rx_s;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit gives the next start edge time to be caught.
          if (cnt == FULL) begin
            cnt <= 8'd0;
            if (rx_s) begin
              o_RX_BYTE <= shift;
              o_RX_DV   <= 1'b1;
            end else begin
              o_RX_ERR   <= 1'b1;
              break_wait <= 1'b1;
            end
            o_RX_ACTIVE <= 1'b0;
            state       <= CLEANUP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        CLEANUP: begin
          cnt   <= 8'd0;
          state <= IDLE;
        end
        default: begin
          cnt         <= 8'd0;
          idx         <= 3'd0;
          o_RX_ACTIVE <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written multi-cycle sequences.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int CPB2 = 87;

  logic       clk;
  logic       rst_n;
  logic       rx1, rx2;
  logic       dv1, act1, err1;
  logic       dv2, act2, err2;
  logic [7:0] byte1, byte2;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_RX_SERIAL(rx1),
    .o_RX_DV(dv1), .o_RX_BYTE(byte1), .o_RX_ACTIVE(act1), .o_RX_ERR(err1)
  );

  uart_rx #(.CLKS_PER_BIT(CPB2)) dut2 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_RX_SERIAL(rx2),
    .o_RX_DV(dv2), .o_RX_BYTE(byte2), .o_RX_ACTIVE(act2), .o_RX_ERR(err2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int fall_cyc = 0;
  int lat1 = 0;
  int dv_cnt = 0, err_cnt = 0, act_cycles = 0, act_rises = 0;
  int dv_act_viol = 0, width_viol = 0, excl_viol = 0;
  int dv2_cnt = 0, err2_cnt = 0;
  logic [7:0] log1 [64];
  logic [7:0] log2 [64];
  logic prev_dv = 1'b0, prev_err = 1'b0, prev_act = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (dv1) begin
      log1[dv_cnt % 64] = byte1;
      dv_cnt++;
      if (act1) dv_act_viol++;
    end
    if (err1) err_cnt++;
    if (dv1 || err1) lat1 = cyc - fall_cyc;
    if ((dv1 && prev_dv) || (err1 && prev_err)) width_viol++;
    if (dv1 && err1) excl_viol++;
    if (act1) act_cycles++;
    if (act1 && !prev_act) act_rises++;
    prev_dv  = dv1;
    prev_err = err1;
    prev_act = act1;
    if (dv2) begin
      log2[dv2_cnt % 64] = byte2;
      dv2_cnt++;
    end
    if (err2) err2_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(input bit which, input logic [7:0] d, input logic stop, input int per);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (which) rx2 = bits[i];
      else rx1 = bits[i];
      if (i == 0 && !which) fall_cyc = cyc;
      repeat (per - 1) @(posedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_dv;
    int         exp_err;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs [6];

  int b_dv, b_err, b_act, b_rise;
  logic [7:0] prior;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[3] = '{8'h5A, 1'b0, 0, 1, 8'hFF};
    vecs[4] = '{8'h01, 1'b1, 1, 0, 8'h01};
    vecs[5] = '{8'h80, 1'b1, 1, 0, 8'h80};

    clk = 1'b0;
    rst_n = 1'b0;
    rx1 = 1'b1;
    rx2 = 1'b1;
    idle(4);
    @(negedge clk);
    check("reset_dv", int'(dv1), 0);
    check("reset_err", int'(err1), 0);
    check("reset_active", int'(act1), 0);
    check("reset_byte", int'(byte1), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(20);

    // Single frames with an idle gap between them.
    for (int v = 0; v < 6; v++) begin
      b_dv = dv_cnt; b_err = err_cnt; b_act = act_cycles; b_rise = act_rises;
      send_frame(1'b0, vecs[v].data, vecs[v].stop, CPB);
      #1 rx1 = 1'b1;
      idle(3 * CPB);
      check($sformatf("vec%0d_dv", v), dv_cnt - b_dv, vecs[v].exp_dv);
      check($sformatf("vec%0d_err", v), err_cnt - b_err, vecs[v].exp_err);
      check($sformatf("vec%0d_byte", v), int'(byte1), int'(vecs[v].exp_byte));
      check_rng($sformatf("vec%0d_latency", v), lat1, 9 * CPB + 7 + 3, 9 * CPB + 7 + 5);
      check_rng($sformatf("vec%0d_active_len", v), act_cycles - b_act, 148, 154);
      check($sformatf("vec%0d_active_rises", v), act_rises - b_rise, 1);
    end

    // Back-to-back frames, no idle gap.
    b_dv = dv_cnt; b_err = err_cnt;
    send_frame(1'b0, 8'h00, 1'b1, CPB);
    send_frame(1'b0, 8'hFF, 1'b1, CPB);
    send_frame(1'b0, 8'h55, 1'b1, CPB);
    idle(3 * CPB);
    check("b2b_dv", dv_cnt - b_dv, 3);
    check("b2b_err", err_cnt - b_err, 0);
    check("b2b_byte0", int'(log1[b_dv % 64]), 8'h00);
    check("b2b_byte1", int'(log1[(b_dv + 1) % 64]), 8'hFF);
    check("b2b_byte2", int'(log1[(b_dv + 2) % 64]), 8'h55);

    // Start-bit glitch of 5 cycles.
    b_dv = dv_cnt; b_err = err_cnt; b_act = act_cycles; b_rise = act_rises;
    prior = byte1;
    @(posedge clk);
    #1 rx1 = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx1 = 1'b1;
    idle(3 * CPB);
    check("glitch_rises", act_rises - b_rise, 1);
    check_rng("glitch_active_len", act_cycles - b_act, 5, 10);
    check("glitch_dv", dv_cnt - b_dv, 0);
    check("glitch_err", err_cnt - b_err, 0);
    check("glitch_byte", int'(byte1), int'(prior));

    // Framing error followed by a 40-bit break, then a good frame.
    b_dv = dv_cnt; b_err = err_cnt; b_rise = act_rises;
    send_frame(1'b0, 8'h3C, 1'b0, CPB);
    idle(40 * CPB);
    check("break_err", err_cnt - b_err, 1);
    check("break_no_dv", dv_cnt - b_dv, 0);
    check("break_rises", act_rises - b_rise, 1);
    check("break_byte", int'(byte1), 8'h55);
    #1 rx1 = 1'b1;
    idle(CPB);
    send_frame(1'b0, 8'h81, 1'b1, CPB);
    idle(3 * CPB);
    check("after_break_dv", dv_cnt - b_dv, 1);
    check("after_break_byte", int'(log1[b_dv % 64]), 8'h81);
    check("after_break_err", err_cnt - b_err, 1);

    // Reset in the middle of data bit 4 of 0x99.
    b_dv = dv_cnt; b_err = err_cnt;
    @(posedge clk);
    #1 rx1 = 1'b0;
    repeat (CPB - 1) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 rx1 = (8'h99 >> i) & 1'b1;
      repeat (CPB - 1) @(posedge clk);
    end
    @(posedge clk);
    #1 rx1 = 1'b1;
    repeat (CPB / 2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_dv", int'(dv1), 0);
    check("midrst_err", int'(err1), 0);
    check("midrst_active", int'(act1), 0);
    check("midrst_byte", int'(byte1), 0);
    idle(5);
    #1 rst_n = 1'b1;
    idle(3 * CPB);
    check("midrst_no_dv", dv_cnt - b_dv, 0);
    send_frame(1'b0, 8'h42, 1'b1, CPB);
    #1 rx1 = 1'b1;
    idle(3 * CPB);
    check("midrst_dv_after", dv_cnt - b_dv, 1);
    check("midrst_byte_after", int'(byte1), 8'h42);
    check("midrst_err_after", err_cnt - b_err, 0);

    // 87 clocks per bit with the sender about 2% slow, then 2% fast.
    send_frame(1'b1, 8'hC3, 1'b1, 89);
    #1 rx2 = 1'b1;
    idle(3 * CPB2);
    send_frame(1'b1, 8'hC3, 1'b1, 85);
    #1 rx2 = 1'b1;
    idle(3 * CPB2);
    check("skew_dv", dv2_cnt, 2);
    check("skew_err", err2_cnt, 0);
    check("skew_slow_byte", int'(log2[0]), 8'hC3);
    check("skew_fast_byte", int'(log2[1]), 8'hC3);

    check("dv_while_active", dv_act_viol, 0);
    check("strobe_width", width_viol, 0);
    check("dv_err_exclusive", excl_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
